// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
// Counts spikes over a fixed window of WINDOW_LEN clock cycles and presents
// each window's count as an 8-bit rate on a valid/ready output port.
// A result that arrives while the previous one is still unconsumed is
// dropped, and the sticky overrun flag is raised.
// Optional feature, enabled by defining SPIKE_DEC_EMA_EN: the block keeps a
// running average of window results and reports that average instead of the
// raw count. The port list and handshake are the same in both builds.

module spike_rate_decoder #(
  parameter logic [15:0] WINDOW_LEN = 16'd256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       spike_i,
  input  logic       enable_i,
  input  logic       ready_i,
  input  logic       clr_overrun_i,
  output logic [7:0] rate_o,
  output logic       valid_o,
  output logic       overrun_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  localparam logic [15:0] LAST_CYCLE = WINDOW_LEN - 16'd1;

  logic [15:0] win_cnt;
  logic [7:0]  spk_cnt;
  logic [7:0]  rate_r;
  logic        overrun_r;
  out_state_t  state;

  logic        win_end;
  logic [8:0]  raw_sum;
  logic [7:0]  result;
  logic [7:0]  load_val;

  // A window closes on the last counting cycle; a spike on that cycle still
  // belongs to the closing window, so it is folded into the result here.
  assign win_end = enable_i && (win_cnt == LAST_CYCLE);
  assign raw_sum = {1'b0, spk_cnt} + {8'd0, spike_i};
  assign result  = raw_sum[8] ? 8'hFF : raw_sum[7:0];

`ifdef SPIKE_DEC_EMA_EN
  logic [7:0] avg_r;
  logic [8:0] avg_sum;
  logic [7:0] avg_next;

  assign avg_sum  = {1'b0, avg_r} + {1'b0, result};
  assign avg_next = avg_sum[8:1];
  assign load_val = avg_next;

  // Running average advances on every window end, even when the output
  // register is busy and the sample itself ends up dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      avg_r <= 8'd0;
    end else if (win_end) begin
      avg_r <= avg_next;
    end
  end
`else
  assign load_val = result;
`endif

  // Window and spike counters; dropping enable restarts the window from
  // scratch, and the spike count saturates rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_cnt <= 16'd0;
      spk_cnt <= 8'd0;
    end else if (!enable_i || (win_cnt == LAST_CYCLE)) begin
      win_cnt <= 16'd0;
      spk_cnt <= 8'd0;
    end else begin
      win_cnt <= win_cnt + 16'd1;
      if (spike_i && (spk_cnt != 8'hFF)) begin
        spk_cnt <= spk_cnt + 8'd1;
      end
    end
  end

  // Output FSM holding one sample; a simultaneous accept and window end
  // replaces the sample in place, while a window end without accept drops
  // the new result and flags it. A same-cycle overrun beats a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= EMPTY;
      rate_r    <= 8'd0;
      overrun_r <= 1'b0;
    end else begin
      if (clr_overrun_i) begin
        overrun_r <= 1'b0;
      end
      case (state)
        EMPTY: begin
          if (win_end) begin
            rate_r <= load_val;
            state  <= FULL;
          end
        end
        FULL: begin
          if (win_end) begin
            if (ready_i) begin
              rate_r <= load_val;
            end else begin
              overrun_r <= 1'b1;
            end
          end else if (ready_i) begin
            state <= EMPTY;
          end
        end
      endcase
    end
  end

  assign rate_o    = rate_r;
  assign valid_o   = (state == FULL);
  assign overrun_o = overrun_r;

endmodule
